// File: rtl/exe_hazard_if.sv
// Handshake bundle between the ID/EX/MEM pipeline and the EXE hazard controller.
// The pipeline side uses the master modport; the controller uses the slave modport.
interface exe_hazard_if #(
    parameter int REG_BITS = 4,
    parameter int CNT_W    = 16
);
    logic                id_valid;
    logic [REG_BITS-1:0] id_rn;
    logic [REG_BITS-1:0] id_rm;
    logic                id_uses_rn;
    logic                id_uses_rm;
    logic [REG_BITS-1:0] id_rd;
    logic                id_writes_rd;
    logic                id_is_mem;
    logic                id_is_load;
    logic                ex_branch_taken;
    logic                mem_ready;
    logic [1:0]          fwd_a_sel;
    logic [1:0]          fwd_b_sel;
    logic                pc_en;
    logic                ifid_en;
    logic                ifid_flush;
    logic                idex_bubble;
    logic                pipe_freeze;
    logic [CNT_W-1:0]    stall_count;
    logic [CNT_W-1:0]    flush_count;

    modport master (
        output id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd, id_writes_rd,
               id_is_mem, id_is_load, ex_branch_taken, mem_ready,
        input  fwd_a_sel, fwd_b_sel, pc_en, ifid_en, ifid_flush, idex_bubble,
               pipe_freeze, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd, id_writes_rd,
               id_is_mem, id_is_load, ex_branch_taken, mem_ready,
        output fwd_a_sel, fwd_b_sel, pc_en, ifid_en, ifid_flush, idex_bubble,
               pipe_freeze, stall_count, flush_count
    );
endinterface

// File: rtl/exe_hazard_controller.sv
// EXE-stage hazard sequencer: operand forwarding, load-use bubbles, branch flush, memory freeze.
// Optional PERF_CNT_EN adds saturating stall/flush counters; undefined ties them to zero.
//
// state    | meaning
// RUN      | pipe advancing; load-use stall and branch flush resolved combinationally
// MEM_WAIT | access in MEM not yet complete; whole pipe frozen until mem_ready
module exe_hazard_controller #(
    parameter int REG_BITS = 4,
    parameter int PC_REG   = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    exe_hazard_if.slave      hz
);
    localparam logic [REG_BITS-1:0] PC_R = REG_BITS'(PC_REG);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                writes;
        logic                is_mem;
        logic                is_load;
    } ex_t;

    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                writes;
        logic                is_mem;
    } mem_t;

    // WB only needs what forwarding looks at
    typedef struct packed {
        logic                valid;
        logic [REG_BITS-1:0] rd;
        logic                writes;
    } wb_t;

    state_t state, state_nxt;
    ex_t    ex_sh, ex_nxt;
    mem_t   mem_sh;
    wb_t    wb_sh;

    logic mem_entry;
    logic load_use;
    logic freeze;
    logic branch;
    logic pc_en, ifid_en, ifid_flush, idex_bubble;
    logic stall_evt;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_BITS-1:0] src,
        input logic                uses,
        input ex_t                 ex,
        input mem_t                mem,
        input wb_t                 wb
    );
        fwd_sel = 2'b00;
        if (uses && src != PC_R) begin
            // a load in EX has no result yet; the load-use bubble handles it
            if (ex.valid && ex.writes && ex.rd == src && !ex.is_load)
                fwd_sel = 2'b01;
            else if (mem.valid && mem.writes && mem.rd == src)
                fwd_sel = 2'b10;
            else if (wb.valid && wb.writes && wb.rd == src)
                fwd_sel = 2'b11;
        end
    endfunction

    assign mem_entry = mem_sh.valid && mem_sh.is_mem && !hz.mem_ready;

    assign load_use = ex_sh.valid && ex_sh.is_load && ex_sh.writes && ex_sh.rd != PC_R &&
                      ((hz.id_uses_rn && hz.id_rn == ex_sh.rd) ||
                       (hz.id_uses_rm && hz.id_rm == ex_sh.rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (mem_entry)    state_nxt = MEM_WAIT;
            MEM_WAIT: if (hz.mem_ready) state_nxt = RUN;
            default:                    state_nxt = RUN;
        endcase
    end

    always_comb begin
        freeze      = (state == MEM_WAIT) ? !hz.mem_ready : mem_entry;
        branch      = !freeze && hz.ex_branch_taken;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_evt   = 1'b0;
        if (freeze) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
        end else if (branch) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            stall_evt   = 1'b1;
        end
        fwd_a = fwd_sel(hz.id_rn, hz.id_uses_rn, ex_sh, mem_sh, wb_sh);
        fwd_b = fwd_sel(hz.id_rm, hz.id_uses_rm, ex_sh, mem_sh, wb_sh);
    end

    always_comb begin
        ex_nxt = '0;
        if (hz.id_valid && !idex_bubble) begin
            ex_nxt.valid   = 1'b1;
            ex_nxt.rd      = hz.id_rd;
            ex_nxt.writes  = hz.id_writes_rd;
            ex_nxt.is_mem  = hz.id_is_mem;
            ex_nxt.is_load = hz.id_is_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_sh  <= '0;
            mem_sh <= '0;
            wb_sh  <= '0;
        end else if (!freeze) begin
            wb_sh  <= '{valid: mem_sh.valid, rd: mem_sh.rd, writes: mem_sh.writes};
            mem_sh <= '{valid: ex_sh.valid, rd: ex_sh.rd, writes: ex_sh.writes,
                        is_mem: ex_sh.is_mem};
            ex_sh  <= ex_nxt;
        end
    end

    assign hz.fwd_a_sel   = fwd_a;
    assign hz.fwd_b_sel   = fwd_b;
    assign hz.pc_en       = pc_en;
    assign hz.ifid_en     = ifid_en;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_bubble = idex_bubble;
    assign hz.pipe_freeze = freeze;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
            if (ifid_flush && flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign hz.stall_count = stall_cnt;
    assign hz.flush_count = flush_cnt;
`else
    logic unused_evt;
    assign unused_evt     = stall_evt;
    assign hz.stall_count = {CNT_W{1'b0}};
    assign hz.flush_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_exe_hazard_controller.sv
// Bench for exe_hazard_controller: directed pipeline scenarios plus randomized traffic
// checked against an in-flight instruction list model.
module tb_exe_hazard_controller;
    localparam int RB = 4;
    localparam int CW = 16;
    localparam int CMAX = (1 << CW) - 1;
`ifdef PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exe_hazard_if #(.REG_BITS(RB), .CNT_W(CW)) hz();
    exe_hazard_controller #(.REG_BITS(RB), .PC_REG(15), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .hz(hz)
    );

    typedef struct {
        bit v;
        int rd;
        bit wr;
        bit mem;
        bit ld;
    } ent_t;

    ent_t pipe[3];   // 0 = EX, 1 = MEM, 2 = WB
    int m_stall, m_flush;
    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]    o_fa, o_fb;
    logic          o_pc, o_ifid, o_fl, o_bub, o_frz;
    logic [CW-1:0] o_sc, o_fc;
    logic [1:0]    e_fa, e_fb;
    logic          e_pc, e_ifid, e_fl, e_bub, e_frz;
    int            e_sc, e_fc;

    function automatic logic [1:0] ref_fwd(int src, bit used);
        if (!used || src == 15) return 2'd0;
        for (int k = 0; k < 3; k++)
            if (pipe[k].v && pipe[k].wr && pipe[k].rd == src && !(k == 0 && pipe[k].ld))
                return 2'(k + 1);
        return 2'd0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
        m_stall = 0;
        m_flush = 0;
    endtask

    task automatic set_id(bit v, int rn, int rm, bit urn, bit urm, int rd, bit wr, bit mem, bit ld);
        hz.id_valid     = v;
        hz.id_rn        = 4'(rn);
        hz.id_rm        = 4'(rm);
        hz.id_uses_rn   = urn;
        hz.id_uses_rm   = urm;
        hz.id_rd        = 4'(rd);
        hz.id_writes_rd = wr;
        hz.id_is_mem    = mem;
        hz.id_is_load   = ld;
    endtask

    task automatic set_nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // one clock: sample at negedge, predict from the model, advance the model at posedge
    task automatic tick();
        bit frz, lu, br;
        ent_t nx;
        @(negedge clk);
        o_fa = hz.fwd_a_sel;  o_fb = hz.fwd_b_sel;
        o_pc = hz.pc_en;      o_ifid = hz.ifid_en;
        o_fl = hz.ifid_flush; o_bub = hz.idex_bubble; o_frz = hz.pipe_freeze;
        o_sc = hz.stall_count; o_fc = hz.flush_count;
        br  = hz.ex_branch_taken;
        frz = pipe[1].v && pipe[1].mem && !hz.mem_ready;
        lu  = pipe[0].v && pipe[0].ld && pipe[0].wr && pipe[0].rd != 15 &&
              ((hz.id_uses_rn && int'(hz.id_rn) == pipe[0].rd) ||
               (hz.id_uses_rm && int'(hz.id_rm) == pipe[0].rd));
        e_frz  = frz;
        e_fl   = !frz && br;
        e_bub  = !frz && (br || lu);
        e_pc   = !frz && (br || !lu);
        e_ifid = e_pc;
        e_fa   = ref_fwd(int'(hz.id_rn), hz.id_uses_rn);
        e_fb   = ref_fwd(int'(hz.id_rm), hz.id_uses_rm);
        e_sc   = PERF ? m_stall : 0;
        e_fc   = PERF ? m_flush : 0;
        @(posedge clk);
        if (!frz) begin
            if (br) begin
                if (m_flush < CMAX) m_flush++;
            end else if (lu) begin
                if (m_stall < CMAX) m_stall++;
            end
            nx.v   = hz.id_valid && !e_bub;
            nx.rd  = int'(hz.id_rd);
            nx.wr  = hz.id_writes_rd;
            nx.mem = hz.id_is_mem;
            nx.ld  = hz.id_is_load;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nx;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_nop();
        hz.ex_branch_taken = 1'b0;
        hz.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        model_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_nop();
        hz.ex_branch_taken = 1'b0;
        hz.mem_ready = 1'b1;
        #2;
        n_cmp++;
        if ({hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_bubble, hz.pipe_freeze,
             hz.fwd_a_sel, hz.fwd_b_sel} !== 9'b1_1_0_0_0_00_00) begin
            n_err++;
            $display("FAIL reset_ctrl got %b want %b", {hz.pc_en, hz.ifid_en, hz.ifid_flush,
                     hz.idex_bubble, hz.pipe_freeze, hz.fwd_a_sel, hz.fwd_b_sel}, 9'b110000000);
        end
        n_cmp++;
        if (hz.stall_count !== '0 || hz.flush_count !== '0) begin
            n_err++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", hz.stall_count, hz.flush_count);
        end
        do_reset();
    endtask

    task automatic test_fwd_back_to_back();
        do_reset();
        set_id(1, 2, 3, 1, 1, 1, 1, 0, 0);       // ADD R1,R2,R3
        tick();
        set_id(1, 1, 3, 1, 1, 2, 1, 0, 0);       // SUB R2,R1,R3
        tick();
        n_cmp++;
        if (o_fa !== 2'b01 || o_fb !== 2'b00) begin
            n_err++;
            $display("FAIL b2b_fwd got a=%0d b=%0d want a=1 b=0", o_fa, o_fb);
        end
        n_cmp++;
        if (o_pc !== 1'b1 || o_bub !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_nostall got pc_en=%b bubble=%b want 1/0", o_pc, o_bub);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 6, 0, 1, 0, 4, 1, 1, 1);       // LDR R4,[R6]
        tick();
        set_id(1, 4, 4, 1, 1, 5, 1, 0, 0);       // ADD R5,R4,R4
        tick();
        n_cmp++;
        if ({o_pc, o_ifid, o_bub, o_fl} !== 4'b0010) begin
            n_err++;
            $display("FAIL lu_stall got pc/ifid/bub/flush=%b want 0010", {o_pc, o_ifid, o_bub, o_fl});
        end
        tick();
        n_cmp++;
        if (o_fa !== 2'b10 || o_fb !== 2'b10) begin
            n_err++;
            $display("FAIL lu_fwd got a=%0d b=%0d want 2/2", o_fa, o_fb);
        end
        n_cmp++;
        if (o_pc !== 1'b1 || o_bub !== 1'b0) begin
            n_err++;
            $display("FAIL lu_one_cycle got pc_en=%b bubble=%b want 1/0", o_pc, o_bub);
        end
        n_cmp++;
        if (o_sc !== CW'(PERF ? 1 : 0)) begin
            n_err++;
            $display("FAIL lu_count got %0d want %0d", o_sc, PERF ? 1 : 0);
        end
    endtask

    task automatic test_fwd_priority();
        do_reset();
        repeat (3) begin
            set_id(1, 2, 3, 1, 1, 1, 1, 0, 0);
            tick();
        end
        set_id(1, 1, 7, 1, 1, 8, 1, 0, 0);
        tick();
        n_cmp++;
        if (o_fa !== 2'b01 || o_fb !== 2'b00) begin
            n_err++;
            $display("FAIL prio_ex got a=%0d b=%0d want 1/0", o_fa, o_fb);
        end
        do_reset();
        repeat (3) begin
            set_id(1, 2, 3, 1, 1, 15, 1, 0, 0);
            tick();
        end
        set_id(1, 15, 15, 1, 1, 8, 1, 0, 0);
        tick();
        n_cmp++;
        if (o_fa !== 2'b00 || o_fb !== 2'b00) begin
            n_err++;
            $display("FAIL prio_pc got a=%0d b=%0d want 0/0", o_fa, o_fb);
        end
        do_reset();
        set_id(1, 2, 3, 1, 1, 9, 1, 0, 0);
        tick();
        set_nop();
        tick();
        set_id(1, 4, 9, 1, 1, 0, 0, 0, 0);
        tick();
        n_cmp++;
        if (o_fb !== 2'b10 || o_fa !== 2'b00) begin
            n_err++;
            $display("FAIL prio_mem got a=%0d b=%0d want 0/2", o_fa, o_fb);
        end
        set_id(1, 9, 9, 1, 0, 0, 0, 0, 0);
        tick();
        n_cmp++;
        if (o_fa !== 2'b11 || o_fb !== 2'b00) begin
            n_err++;
            $display("FAIL prio_wb got a=%0d b=%0d want 3/0", o_fa, o_fb);
        end
    endtask

    task automatic test_branch_vs_load_use();
        do_reset();
        set_id(1, 6, 0, 1, 0, 4, 1, 1, 1);
        tick();
        set_id(1, 4, 2, 1, 1, 5, 1, 0, 0);
        hz.ex_branch_taken = 1'b1;
        tick();
        n_cmp++;
        if ({o_fl, o_bub, o_pc, o_ifid} !== 4'b1111) begin
            n_err++;
            $display("FAIL br_lu got flush/bub/pc/ifid=%b want 1111", {o_fl, o_bub, o_pc, o_ifid});
        end
        hz.ex_branch_taken = 1'b0;
        set_nop();
        tick();
        n_cmp++;
        if (o_fc !== CW'(PERF ? 1 : 0) || o_sc !== '0) begin
            n_err++;
            $display("FAIL br_counts got flush=%0d stall=%0d want %0d/0", o_fc, o_sc, PERF ? 1 : 0);
        end
    endtask

    task automatic test_mem_freeze();
        do_reset();
        set_id(1, 2, 3, 1, 1, 0, 0, 1, 0);       // STR
        tick();
        set_id(1, 2, 3, 1, 1, 6, 1, 0, 0);
        tick();
        set_id(1, 6, 1, 1, 1, 7, 1, 0, 0);
        hz.ex_branch_taken = 1'b1;
        hz.mem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if ({o_frz, o_pc, o_ifid, o_fl, o_bub} !== 5'b10000) begin
                n_err++;
                $display("FAIL freeze_c%0d got frz/pc/ifid/fl/bub=%b want 10000", c,
                         {o_frz, o_pc, o_ifid, o_fl, o_bub});
            end
        end
        hz.mem_ready = 1'b1;
        tick();
        n_cmp++;
        if ({o_frz, o_pc, o_fl, o_bub} !== 4'b0111) begin
            n_err++;
            $display("FAIL freeze_release got frz/pc/fl/bub=%b want 0111", {o_frz, o_pc, o_fl, o_bub});
        end
        hz.ex_branch_taken = 1'b0;
        set_nop();
        tick();
        n_cmp++;
        if (o_fc !== CW'(PERF ? 1 : 0)) begin
            n_err++;
            $display("FAIL freeze_flush_cnt got %0d want %0d", o_fc, PERF ? 1 : 0);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        hz.ex_branch_taken = 1'b1;
        tick();
        hz.ex_branch_taken = 1'b0;
        set_id(1, 2, 3, 1, 1, 0, 0, 1, 0);
        tick();
        set_nop();
        tick();
        hz.mem_ready = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (o_frz !== 1'b1 || o_fc !== CW'(PERF ? 1 : 0)) begin
            n_err++;
            $display("FAIL wait_entered got frz=%b flush_cnt=%0d want 1/%0d", o_frz, o_fc, PERF ? 1 : 0);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_bubble, hz.pipe_freeze,
             hz.fwd_a_sel, hz.fwd_b_sel} !== 9'b110000000 ||
            hz.stall_count !== '0 || hz.flush_count !== '0) begin
            n_err++;
            $display("FAIL async_reset got ctrl=%b cnt=%0d/%0d want 110000000 0/0",
                     {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_bubble, hz.pipe_freeze,
                      hz.fwd_a_sel, hz.fwd_b_sel}, hz.stall_count, hz.flush_count);
        end
        #2;
        rst_n = 1'b1;
        model_clear();
        tick();
        n_cmp++;
        if (o_frz !== 1'b0 || o_pc !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset_run got frz=%b pc_en=%b want 0/1", o_frz, o_pc);
        end
        hz.mem_ready = 1'b1;
    endtask

    function automatic int rreg();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 8) return r % 4;
        if (r == 8) return 15;
        return int'($urandom_range(0, 15));
    endfunction

    task automatic test_random();
        bit mem, ld;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            mem = ($urandom_range(0, 9) < 3);
            ld  = mem && $urandom_range(0, 1);
            set_id($urandom_range(0, 3) != 0, rreg(), rreg(), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), rreg(), 1'($urandom_range(0, 1)) | ld, mem, ld);
            hz.ex_branch_taken = ($urandom_range(0, 9) == 0);
            hz.mem_ready       = ($urandom_range(0, 9) < 7);
            tick();
            n_cmp++;
            if ({o_fa, o_fb, o_pc, o_ifid, o_fl, o_bub, o_frz} !==
                {e_fa, e_fb, e_pc, e_ifid, e_fl, e_bub, e_frz}) begin
                n_err++;
                $display("FAIL rand_ctrl cyc %0d got %b want %b", i,
                         {o_fa, o_fb, o_pc, o_ifid, o_fl, o_bub, o_frz},
                         {e_fa, e_fb, e_pc, e_ifid, e_fl, e_bub, e_frz});
            end
            n_cmp++;
            if (o_sc !== CW'(e_sc) || o_fc !== CW'(e_fc)) begin
                n_err++;
                $display("FAIL rand_cnt cyc %0d got %0d/%0d want %0d/%0d", i, o_sc, o_fc, e_sc, e_fc);
            end
        end
        hz.ex_branch_taken = 1'b0;
        hz.mem_ready = 1'b1;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fwd_back_to_back();
        test_load_use();
        test_fwd_priority();
        test_branch_vs_load_use();
        test_mem_freeze();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/exe_hazard_controller.md
Name: exe_hazard_controller

Overview:
Pipeline sequencer for the EXE stage (ALU, shifter/sign-extender, condition handler, status register).
- Tracks destination registers of the in-flight instructions in EX, MEM and WB.
- Drives forwarding selects for the ALU A (Rn) and B (Rm) operands.
- Inserts load-use bubbles, flushes on taken branches, and freezes the pipe while data memory is busy.

Parameters:
REG_BITS, 4, register specifier width (R0-R15)
PC_REG, 15, register number that is never forwarded (PC)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID stage holds a real instruction
id_rn  in  REG_BITS  Rn specifier
id_rm  in  REG_BITS  Rm specifier
id_uses_rn  in  1  instruction reads Rn
id_uses_rm  in  1  instruction reads Rm
id_rd  in  REG_BITS  destination specifier
id_writes_rd  in  1  instruction writes Rd
id_is_mem  in  1  load or store
id_is_load  in  1  load (implies id_is_mem)
ex_branch_taken  in  1  condition handler output for the instruction in EX
mem_ready  in  1  data memory completes the access in MEM this cycle
fwd_a_sel  out  2  00 regfile, 01 EX result, 10 MEM result, 11 WB result
fwd_b_sel  out  2  same encoding, Rm operand
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID register enable
ifid_flush  out  1  clear IF/ID to NOP
idex_bubble  out  1  load NOP into ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
stall_count  out  CNT_W  load-use stall cycles (PERF_CNT_EN only)
flush_count  out  CNT_W  taken-branch flushes (PERF_CNT_EN only)

Behaviour:
Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.

Reset:
- All shadow entries (EX, MEM, WB: valid, rd, writes, is_mem, is_load) cleared.
- FSM in RUN.
- Outputs: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, pipe_freeze=0, fwd selects 00, counters 0.
- Reset mid-stall or mid-wait returns to RUN immediately.

FSM states:
- RUN to MEM_WAIT: MEM entry valid & is_mem & !mem_ready.
- MEM_WAIT to RUN: on the cycle mem_ready=1.
- The load-use stall is combinational in RUN; no extra state.

Precedence, highest first:
1. Freeze (MEM_WAIT or the entry condition above): pipe_freeze=1, pc_en=0, ifid_en=0. No flush, no bubble. Shadow entries hold. A branch pending in EX is deferred until the freeze releases.
2. Branch: ex_branch_taken=1 drives ifid_flush=1 and idex_bubble=1. Next EX shadow entry is invalid; EX shifts to MEM normally. pc_en stays 1 so the branch target loads.
3. Load-use: EX valid & is_load & writes & rd != PC_REG, and rd equals a used ID source. Drives pc_en=0, ifid_en=0, idex_bubble=1 for exactly one cycle. The following cycle forwards from MEM.

Shadow advance when not frozen:
- WB takes MEM, MEM takes EX.
- EX takes the ID fields, qualified by id_valid & !idex_bubble.

Forwarding (combinational, per operand):
- Match requires valid & writes & rd == source & source != PC_REG & uses_x.
- Priority EX (01) > MEM (10) > WB (11) > regfile (00).
- An EX match on a load never selects 01; the stall covers it.

Optional Feature:
PERF_CNT_EN:
- Defined: stall_count increments each load-use stall cycle; flush_count increments each taken-branch flush. Both saturate at all-ones, clear on reset, and do not count freeze cycles.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- ADD R1 then SUB R2,R1,R3 back-to-back -> fwd_a_sel=01 during SUB's EX cycle, no stall.
- LDR R4 then ADD R5,R4,R4 -> one cycle with pc_en=0, ifid_en=0, idex_bubble=1; next cycle fwd_a_sel=fwd_b_sel=10; stall_count=1.
- Writes to R1 in EX, MEM and WB at once, consumer reads R1 -> fwd_a_sel=01. Producer rd=15 -> fwd 00.
- ex_branch_taken=1 with a load-use condition also present -> ifid_flush=1, idex_bubble=1, pc_en=1; flush_count=1, stall_count unchanged.
- STR in MEM with mem_ready low for 3 cycles and branch taken in EX -> pipe_freeze=1 for 3 cycles, no flush; flush asserted the cycle mem_ready=1.
- rst_n low during MEM_WAIT -> all outputs return to reset values asynchronously; counters 0.
